// File: rtl/bp_be_stride_detector_pkg.sv
// Shared types and constants for the committed-load stride detector.
package bp_be_stride_detector_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int vaddr_width_gp = 39;
  localparam int cool_width_gp  = 16;

  localparam logic [1:0] conf_max_gp = 2'd3;

  typedef struct packed {
    logic                      v;
    logic [vaddr_width_gp-1:0] tag;
    logic [vaddr_width_gp-1:0] last_addr;
    logic [vaddr_width_gp-1:0] stride;
    logic [1:0]                conf;
    logic [cool_width_gp-1:0]  cool;
  } bp_be_stride_entry_s;

  function automatic int bp_vaddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return vaddr_width_gp;
      default:          return vaddr_width_gp;
    endcase
  endfunction

endpackage

// File: rtl/bp_be_stride_entry.sv
// One stride-table entry: PC match, delta/stride compare, confidence and cooldown update.
// BP_BE_STRIDE_ADAPTIVE_DEGREE_EN exposes the post-update confidence for degree scaling.
module bp_be_stride_entry
  import bp_be_stride_detector_pkg::*;
#(
  parameter int stride_width_p = 8,
  parameter int loop_range_p   = 8,
  parameter int conf_thresh_p  = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      clear_i,
  input  logic                      train_i,
  input  logic [vaddr_width_gp-1:0] pc_i,
  input  logic [vaddr_width_gp-1:0] addr_i,
  input  logic                      alloc_i,
  input  logic                      issue_i,
  input  logic [loop_range_p-1:0]   issue_count_i,
  output logic                      hit_o,
  output logic                      trigger_o,
`ifdef BP_BE_STRIDE_ADAPTIVE_DEGREE_EN
  output logic [1:0]                conf_o,
`endif
  output logic [stride_width_p-1:0] stride_o
);

  localparam logic signed [vaddr_width_gp-1:0] stride_lim_lp =
    {{(vaddr_width_gp-1){1'b0}}, 1'b1} << stride_width_p;

  function automatic logic [1:0] sat_conf_inc(input logic [1:0] c);
    return (c == conf_max_gp) ? conf_max_gp : c + 2'd1;
  endfunction

  bp_be_stride_entry_s ent_r, ent_n;

  logic signed [vaddr_width_gp-1:0] delta_p0;
  logic                             in_range_p0;
  logic                             same_p0;
  logic [vaddr_width_gp-1:0]        stride_nxt;
  logic [1:0]                       conf_nxt;

  // Stage p0: compare the committing load against this entry
  assign hit_o       = train_i & ent_r.v & (ent_r.tag == pc_i);
  assign delta_p0    = signed'(addr_i - ent_r.last_addr);
  assign in_range_p0 = ~delta_p0[vaddr_width_gp-1] && (delta_p0 != '0)
                       && (delta_p0 < stride_lim_lp);
  assign same_p0     = in_range_p0 && (ent_r.stride == unsigned'(delta_p0));

  always_comb begin
    conf_nxt   = ent_r.conf;
    stride_nxt = ent_r.stride;
    if (same_p0) begin
      conf_nxt = sat_conf_inc(ent_r.conf);
    end else begin
      conf_nxt   = 2'd0;
      stride_nxt = in_range_p0 ? unsigned'(delta_p0) : '0;
    end
  end

  // Cooldown is judged on the pre-update value so an issue is never immediately repeated.
  assign trigger_o = hit_o && (conf_nxt >= 2'(conf_thresh_p)) && (stride_nxt != '0)
                     && (ent_r.cool == '0);
  assign stride_o  = stride_nxt[stride_width_p-1:0];
`ifdef BP_BE_STRIDE_ADAPTIVE_DEGREE_EN
  assign conf_o    = conf_nxt;
`endif

  always_comb begin
    ent_n = ent_r;
    if (clear_i) begin
      ent_n.v = 1'b0;
    end else if (alloc_i) begin
      ent_n.v         = 1'b1;
      ent_n.tag       = pc_i;
      ent_n.last_addr = addr_i;
      ent_n.stride    = '0;
      ent_n.conf      = 2'd0;
      ent_n.cool      = '0;
    end else if (hit_o) begin
      ent_n.last_addr = addr_i;
      ent_n.stride    = stride_nxt;
      ent_n.conf      = conf_nxt;
      if (!same_p0) begin
        ent_n.cool = '0;
      end else if (ent_r.cool != '0) begin
        ent_n.cool = ent_r.cool - cool_width_gp'(1);
      end
      if (issue_i) begin
        ent_n.cool = cool_width_gp'(issue_count_i);
      end
    end
  end

  // Stage p1: entry state register; only the valid bit needs reset
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      ent_r.v <= 1'b0;
    end else begin
      ent_r <= ent_n;
    end
  end

endmodule

// File: rtl/bp_be_stride_detector.sv
// Committed-load stride detector: trains a PC-tagged table and emits prefetch descriptors.
// BP_BE_STRIDE_ADAPTIVE_DEGREE_EN scales the prefetch count with confidence.
module bp_be_stride_detector
  import bp_be_stride_detector_pkg::*;
#(
  parameter bp_params_e bp_params_p      = e_bp_default_cfg,
  parameter int         entries_p         = 4,
  parameter int         stride_width_p    = 8,
  parameter int         loop_range_p      = 8,
  parameter int         conf_thresh_p     = 2,
  parameter int         prefetch_degree_p = 4,
  localparam int        vaddr_width_p     = bp_vaddr_width(bp_params_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      clear_i,
  input  logic                      commit_v_i,
  input  logic                      commit_load_i,
  input  logic [vaddr_width_p-1:0]  commit_pc_i,
  input  logic [vaddr_width_p-1:0]  commit_addr_i,
  output logic                      v_o,
  input  logic                      ready_and_i,
  output logic [vaddr_width_p-1:0]  pc_o,
  output logic [vaddr_width_p-1:0]  eff_addr_o,
  output logic [stride_width_p-1:0] stride_o,
  output logic [loop_range_p-1:0]   loop_counter_o
);

  localparam int idx_w_lp = (entries_p > 1) ? $clog2(entries_p) : 1;

  logic                      train_p0;
  logic [entries_p-1:0]      hit_vec, trig_vec, alloc_vec;
  logic [stride_width_p-1:0] stride_vec [entries_p];
  logic [idx_w_lp-1:0]       hit_idx_p0;
  logic [idx_w_lp-1:0]       victim_r;
  logic                      hit_any_p0, trig_any_p0, accept_p0;
  logic [loop_range_p-1:0]   loop_cnt_p0;

  logic                      vld_p1;
  logic [vaddr_width_p-1:0]  pc_p1, addr_p1;
  logic [stride_width_p-1:0] stride_p1;
  logic [loop_range_p-1:0]   loop_p1;

`ifdef BP_BE_STRIDE_ADAPTIVE_DEGREE_EN
  localparam int wide_w_lp = loop_range_p + 4;

  logic [1:0] conf_vec [entries_p];
  logic [1:0] hit_conf_p0;

  function automatic logic [loop_range_p-1:0] sat_loop_count(input logic [1:0] conf);
    logic [wide_w_lp-1:0] wide;
    logic [1:0]           sh;
    sh   = conf - 2'(conf_thresh_p);
    wide = wide_w_lp'(prefetch_degree_p) << sh;
    if (wide[wide_w_lp-1:loop_range_p] != '0) return '1;
    return wide[loop_range_p-1:0];
  endfunction

  assign hit_conf_p0 = conf_vec[hit_idx_p0];
  assign loop_cnt_p0 = sat_loop_count(hit_conf_p0);
`else
  assign loop_cnt_p0 = loop_range_p'(prefetch_degree_p);
`endif

  // Stage p0: train decode, hit encode, allocation and issue decisions
  assign train_p0 = commit_v_i & commit_load_i;

  for (genvar g = 0; g < entries_p; g++) begin : g_entry
    bp_be_stride_entry #(
      .stride_width_p(stride_width_p),
      .loop_range_p  (loop_range_p),
      .conf_thresh_p (conf_thresh_p)
    ) u_entry (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .clear_i      (clear_i),
      .train_i      (train_p0),
      .pc_i         (commit_pc_i),
      .addr_i       (commit_addr_i),
      .alloc_i      (alloc_vec[g]),
      .issue_i      (accept_p0),
      .issue_count_i(loop_cnt_p0),
      .hit_o        (hit_vec[g]),
      .trigger_o    (trig_vec[g]),
`ifdef BP_BE_STRIDE_ADAPTIVE_DEGREE_EN
      .conf_o       (conf_vec[g]),
`endif
      .stride_o     (stride_vec[g])
    );
  end

  always_comb begin
    hit_idx_p0 = '0;
    for (int i = 0; i < entries_p; i++) begin
      if (hit_vec[i]) hit_idx_p0 = idx_w_lp'(i);
    end
  end

  assign hit_any_p0  = |hit_vec;
  assign trig_any_p0 = |trig_vec;
  // A trigger is dropped (and its entry left un-cooled) when the held descriptor is not leaving.
  assign accept_p0   = trig_any_p0 & ~clear_i & (~vld_p1 | ready_and_i);

  always_comb begin
    alloc_vec = '0;
    for (int i = 0; i < entries_p; i++) begin
      alloc_vec[i] = train_p0 & ~hit_any_p0 & ~clear_i & (victim_r == idx_w_lp'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      victim_r <= '0;
    end else if (train_p0 & ~hit_any_p0 & ~clear_i) begin
      victim_r <= (victim_r == idx_w_lp'(entries_p - 1)) ? '0 : victim_r + idx_w_lp'(1);
    end
  end

  // Stage p1: descriptor output register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      vld_p1    <= 1'b0;
      pc_p1     <= '0;
      addr_p1   <= '0;
      stride_p1 <= '0;
      loop_p1   <= '0;
    end else if (clear_i) begin
      vld_p1 <= 1'b0;
    end else if (accept_p0) begin
      vld_p1    <= 1'b1;
      pc_p1     <= commit_pc_i;
      addr_p1   <= commit_addr_i;
      stride_p1 <= stride_vec[hit_idx_p0];
      loop_p1   <= loop_cnt_p0;
    end else if (vld_p1 & ready_and_i) begin
      vld_p1 <= 1'b0;
    end
  end

  assign v_o            = vld_p1;
  assign pc_o           = pc_p1;
  assign eff_addr_o     = addr_p1;
  assign stride_o       = stride_p1;
  assign loop_counter_o = loop_p1;

endmodule
